// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, funct codes, ALU control and ALU-op classes.
// Used by both the multicycle and single-cycle controllers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10,
        AluOpRsvd  = 2'b11
    } aluop_e;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the controller's ALU-op class and the R-type funct field
// onto the 3-bit ALU operation.
module aludec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    input  aluop_e     aluop,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            AluOpAdd: alucontrol = ALU_ADD;
            AluOpSub: alucontrol = ALU_SUB;
            AluOpFunct: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore sequencing FSM plus ALU decoder.
// pcen is the only output that also depends on the ALU zero flag.
module mips_multicycle_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       pcen,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    state_e state_q, state_d;
    logic   pcwrite;
    logic   branch;
    aluop_e aluop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = StFetch;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = AluOpAdd;

        case (state_q)
            StFetch: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
                state_d = StDecode;
            end
            StDecode: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExecute;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
                    // Unknown opcodes retire as NOPs; PC already advanced in fetch.
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord    = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            StExecute: begin
                alusrca = 1'b1;
                aluop   = AluOpFunct;
                state_d = StAluWb;
            end
            StAluWb: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            StBranch: begin
                alusrca = 1'b1;
                aluop   = AluOpSub;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = StAddiWb;
            end
            StAddiWb: begin
                regwrite = 1'b1;
            end
            StJump: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        // While in reset, present the fetch datapath setup with every write disabled.
        if (!reset_n) begin
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            iord     = 1'b0;
            memtoreg = 1'b0;
            regdst   = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = 2'b01;
            pcsrc    = 2'b00;
            aluop    = AluOpAdd;
        end
    end

    assign pcen = pcwrite | (branch & zero);

    aludec u_aludec (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench: stimulus pushes the expected control word per cycle, a
// negedge monitor pops and compares against the controller outputs.
module tb_mips_multicycle_controller;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    mips_multicycle_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .pcen       (pcen),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol)
    );

    localparam int P_RESET  = 0;
    localparam int P_FETCH  = 1;
    localparam int P_DECODE = 2;
    localparam int P_MEMADR = 3;
    localparam int P_MEMRD  = 4;
    localparam int P_MEMWB  = 5;
    localparam int P_MEMWR  = 6;
    localparam int P_EXEC   = 7;
    localparam int P_ALUWB  = 8;
    localparam int P_BRANCH = 9;
    localparam int P_ADDIEX = 10;
    localparam int P_ADDIWB = 11;
    localparam int P_JUMP   = 12;

    typedef struct {
        logic [14:0] cw;
        int          ph;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Control word: {memwrite,irwrite,regwrite,pcen,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,aluctl}
    function automatic logic [14:0] expect_cw(input int ph, input logic [5:0] fn, input logic z);
        logic mw, iw, rw, pe, io, mr, rd, sa;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {mw, iw, rw, pe, io, mr, rd, sa} = 8'b0;
        sb = 2'b00;
        ps = 2'b00;
        ac = 3'b010;
        case (ph)
            P_RESET:  sb = 2'b01;
            P_FETCH:  begin iw = 1'b1; pe = 1'b1; sb = 2'b01; end
            P_DECODE: sb = 2'b11;
            P_MEMADR: begin sa = 1'b1; sb = 2'b10; end
            P_MEMRD:  io = 1'b1;
            P_MEMWB:  begin mr = 1'b1; rw = 1'b1; end
            P_MEMWR:  begin io = 1'b1; mw = 1'b1; end
            P_EXEC:   begin sa = 1'b1; ac = rtype_alu(fn); end
            P_ALUWB:  begin rd = 1'b1; rw = 1'b1; end
            P_BRANCH: begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = z; end
            P_ADDIEX: begin sa = 1'b1; sb = 2'b10; end
            P_ADDIWB: rw = 1'b1;
            P_JUMP:   begin ps = 2'b10; pe = 1'b1; end
            default:  ;
        endcase
        return {mw, iw, rw, pe, io, mr, rd, sa, sb, ps, ac};
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
               o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
    endfunction

    task automatic push(input int ph);
        exp_t e;
        e.cw = expect_cw(ph, funct, zero);
        e.ph = ph;
        q.push_back(e);
    endtask

    // Runs one instruction from FETCH; abort_at >= 0 pulls reset low in that cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic zb,
                             input int abort_at);
        int ph[$];
        ph = '{P_FETCH, P_DECODE};
        case (o)
            6'b100011: ph = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB};
            6'b101011: ph = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMWR};
            6'b000000: ph = '{P_FETCH, P_DECODE, P_EXEC, P_ALUWB};
            6'b000100: ph = '{P_FETCH, P_DECODE, P_BRANCH};
            6'b001000: ph = '{P_FETCH, P_DECODE, P_ADDIEX, P_ADDIWB};
            6'b000010: ph = '{P_FETCH, P_DECODE, P_JUMP};
            default:   ;
        endcase
        for (int i = 0; i < ph.size(); i++) begin
            op    = (i == 0) ? 6'($urandom) : o;
            funct = (i == 0) ? 6'($urandom) : f;
            zero  = (ph[i] == P_BRANCH) ? zb : 1'($urandom);
            if (i == abort_at) begin
                reset_n = 1'b0;
                push(P_RESET);
                @(posedge clk);
                #1;
                reset_n = 1'b1;
                return;
            end
            push(ph[i]);
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [14:0] act;
        cycle++;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca,
                   alusrcb, pcsrc, alucontrol};
            checks++;
            if (act !== e.cw) begin
                failures++;
                $display("FAIL ctl cycle=%0d phase=%0d got=%b want=%b", cycle, e.ph, act, e.cw);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] o, f;
        int k, ab;
        reset_n = 1'b0;
        op      = 6'b100011;
        funct   = 6'b000000;
        zero    = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) begin
            zero = 1'($urandom);
            push(P_RESET);
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;

        run_instr(6'b100011, 6'b000000, 1'b0, -1);
        run_instr(6'b000000, 6'b101010, 1'b0, -1);
        run_instr(6'b000000, 6'b100010, 1'b0, -1);
        run_instr(6'b000100, 6'b000000, 1'b1, -1);
        run_instr(6'b000100, 6'b000000, 1'b0, -1);
        run_instr(6'b000010, 6'b000000, 1'b0, -1);
        run_instr(6'b111111, 6'b000000, 1'b0, -1);
        run_instr(6'b101011, 6'b000000, 1'b0, 2);
        run_instr(6'b101011, 6'b000000, 1'b0, -1);
        run_instr(6'b001000, 6'b000000, 1'b0, -1);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 6);
            f = 6'($urandom);
            case (k)
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: begin
                    o = 6'b000000;
                    if ($urandom_range(0, 3) != 0) begin
                        case ($urandom_range(0, 4))
                            0: f = 6'b100000;
                            1: f = 6'b100010;
                            2: f = 6'b100100;
                            3: f = 6'b100101;
                            default: f = 6'b101010;
                        endcase
                    end
                end
                3: o = 6'b000100;
                4: o = 6'b001000;
                5: o = 6'b000010;
                default: begin
                    o = 6'($urandom);
                    while (is_legal(o)) o = 6'($urandom);
                end
            endcase
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(o, f, 1'($urandom), ab);
        end

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
